// File: rtl/pipe_pkg.sv
// Shared pipeline constants used by the execute, data-memory and write-back stages.
package pipe_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREG   = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO  = '0;
  localparam logic [DATA_W-1:0] DATA_ZERO = '0;

  // True when a write-back to waddr targets raddr (R0 never counts as a write).
  function automatic logic wr_hits(input logic [ADDR_W-1:0] waddr,
                                   input logic [ADDR_W-1:0] raddr);
    return (waddr != REG_ZERO) && (waddr == raddr);
  endfunction

endpackage

// File: rtl/reg_bank_wb_if.sv
// Bus between the data-memory/decode side and the write-back register bank.
interface reg_bank_wb_if;
  import pipe_pkg::*;

  logic [DATA_W-1:0] mux_ans_dm;
  logic [ADDR_W-1:0] RW_dm;
  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic              stall;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [DATA_W-1:0] ans_wb;
  logic [ADDR_W-1:0] RW_wb;

  modport master (
    output mux_ans_dm, RW_dm, RA, RB, stall,
    input  A, B, ans_wb, RW_wb
  );

  modport slave (
    input  mux_ans_dm, RW_dm, RA, RB, stall,
    output A, B, ans_wb, RW_wb
  );

endinterface

// File: rtl/reg_bank_read_port.sv
// One registered read port: address hold under stall, zero/bypass mux, output register.
module reg_bank_read_port
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              stall,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] sel_addr,
  input  logic [DATA_W-1:0] bank_data,
  output logic [DATA_W-1:0] rdata
);

  logic [ADDR_W-1:0] held_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_hit;

  assign sel_addr = stall ? held_q : raddr;
  assign wr_hit   = wr_hits(waddr, sel_addr);

  // Under stall the output only moves when the held register is rewritten, so it
  // never goes stale while decode is frozen.
  always_comb begin
    data_d = data_q;
    if (stall) begin
      if (wr_hit) data_d = wdata;
    end else if (sel_addr == REG_ZERO) begin
      data_d = DATA_ZERO;
    end else if (wr_hit) begin
      data_d = wdata;
    end else begin
      data_d = bank_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q <= REG_ZERO;
      data_q <= DATA_ZERO;
    end else begin
      held_q <= sel_addr;
      data_q <= data_d;
    end
  end

  assign rdata = data_q;

endmodule

// File: rtl/reg_bank_wb.sv
// Write-back stage: 32x8 register bank, two bypassed read ports, commit echo.
module reg_bank_wb
  import pipe_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  reg_bank_wb_if.slave bus
);

  logic [DATA_W-1:0] bank_q [NREG];
  logic [DATA_W-1:0] ans_q;
  logic [ADDR_W-1:0] rw_q;
  logic [ADDR_W-1:0] sel_a, sel_b;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  // R0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) bank_q[i] <= DATA_ZERO;
    end else if (bus.RW_dm != REG_ZERO) begin
      bank_q[bus.RW_dm] <= bus.mux_ans_dm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ans_q <= DATA_ZERO;
      rw_q  <= REG_ZERO;
    end else begin
      ans_q <= bus.mux_ans_dm;
      rw_q  <= bus.RW_dm;
    end
  end

  reg_bank_read_port u_port_a (
    .clk       (clk),
    .reset     (reset),
    .raddr     (bus.RA),
    .stall     (bus.stall),
    .waddr     (bus.RW_dm),
    .wdata     (bus.mux_ans_dm),
    .sel_addr  (sel_a),
    .bank_data (bank_q[sel_a]),
    .rdata     (rdata_a)
  );

  reg_bank_read_port u_port_b (
    .clk       (clk),
    .reset     (reset),
    .raddr     (bus.RB),
    .stall     (bus.stall),
    .waddr     (bus.RW_dm),
    .wdata     (bus.mux_ans_dm),
    .sel_addr  (sel_b),
    .bank_data (bank_q[sel_b]),
    .rdata     (rdata_b)
  );

  assign bus.A      = rdata_a;
  assign bus.B      = rdata_b;
  assign bus.ans_wb = ans_q;
  assign bus.RW_wb  = rw_q;

endmodule
